// File: rtl/fifo_pkg.sv
// Shared constants and width helpers for the parametrised synchronous FIFO.
package fifo_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Count needs one extra bit to represent a completely full FIFO.
    function automatic int cnt_w(input int depth);
        return addr_w(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// Write/read handshake, status and error signals of the FIFO.
interface sync_fifo_param_if
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int DATA_DEPTH = 16
);
    localparam int CW = cnt_w(DATA_DEPTH);

    logic                  clr;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  full;
    logic                  almost_full;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_valid;
    logic                  empty;
    logic                  almost_empty;
    logic [CW-1:0]         fill_count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output clr, wr_en, data_in, rd_en,
        input  full, almost_full, data_out, data_valid, empty, almost_empty,
               fill_count, overflow, underflow
    );

    modport slave (
        input  clr, wr_en, data_in, rd_en,
        output full, almost_full, data_out, data_valid, empty, almost_empty,
               fill_count, overflow, underflow
    );

endinterface

// File: rtl/fifo_mem_2p.sv
// Storage array: synchronous write port, asynchronous read port, no reset.
module fifo_mem_2p
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int DATA_DEPTH = 16,
    parameter int ADDR_WIDTH = addr_w(DATA_DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised synchronous FIFO with internal pointers, thresholds, FWFT option and sticky errors.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH    = 16,
    parameter int DATA_DEPTH    = 16,
    parameter int AFULL_THRESH  = DATA_DEPTH - 2,
    parameter int AEMPTY_THRESH = 2,
    parameter int FWFT          = FIFO_MODE_STD
) (
    input  logic clk,
    input  logic rst,
    sync_fifo_param_if.slave bus
);
    localparam int ADDR_WIDTH = addr_w(DATA_DEPTH);
    localparam int CW         = cnt_w(DATA_DEPTH);

    localparam logic [CW-1:0]         DEPTH_C  = DATA_DEPTH[CW-1:0];
    localparam logic [CW-1:0]         AFULL_C  = AFULL_THRESH[CW-1:0];
    localparam logic [CW-1:0]         AEMPTY_C = AEMPTY_THRESH[CW-1:0];
    localparam logic [CW-1:0]         CNT_ONE  = 1;
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = 1;

    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0]         cnt;
    logic                  full, empty;
    logic                  wr_acc, rd_acc;
    logic                  ovf, unf;
    logic [DATA_WIDTH-1:0] rdata;

    // Flags decode from the registered count, so accepts see pre-edge state.
    assign full   = (cnt == DEPTH_C);
    assign empty  = (cnt == '0);
    assign wr_acc = bus.wr_en & ~full & ~bus.clr;
    assign rd_acc = bus.rd_en & ~empty & ~bus.clr;

    fifo_mem_2p #(
        .DATA_WIDTH (DATA_WIDTH),
        .DATA_DEPTH (DATA_DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr),
        .wdata (bus.data_in),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
            unf    <= 1'b0;
        end else if (bus.clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
            unf    <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
            if (wr_acc && !rd_acc)      cnt <= cnt + CNT_ONE;
            else if (rd_acc && !wr_acc) cnt <= cnt - CNT_ONE;
            if (bus.wr_en && full)  ovf <= 1'b1;
            if (bus.rd_en && empty) unf <= 1'b1;
        end
    end

    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (cnt >= AFULL_C);
    assign bus.almost_empty = (cnt <= AEMPTY_C);
    assign bus.fill_count   = cnt;
    assign bus.overflow     = ovf;
    assign bus.underflow    = unf;

    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
        assign bus.data_out   = empty ? '0 : rdata;
        assign bus.data_valid = ~empty;
    end else begin : g_std
        logic [DATA_WIDTH-1:0] dout_q;
        logic                  dv_q;

        // Flush leaves the last read word on data_out; only a reset clears it.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                dout_q <= '0;
                dv_q   <= 1'b0;
            end else if (bus.clr) begin
                dv_q   <= 1'b0;
            end else begin
                dv_q <= rd_acc;
                if (rd_acc) dout_q <= rdata;
            end
        end

        assign bus.data_out   = dout_q;
        assign bus.data_valid = dv_q;
    end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Randomised and directed checks of standard and FWFT FIFOs against a queue model.
module tb_sync_fifo_param;
    localparam int DW    = 16;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wr_en = 1'b0, rd_en = 1'b0, clr = 1'b0;
    logic [DW-1:0] data_in = '0;

    sync_fifo_param_if #(.DATA_WIDTH(DW), .DATA_DEPTH(DEPTH)) bus_s ();
    sync_fifo_param_if #(.DATA_WIDTH(DW), .DATA_DEPTH(DEPTH)) bus_f ();

    assign bus_s.clr = clr;  assign bus_s.wr_en = wr_en;
    assign bus_s.rd_en = rd_en;  assign bus_s.data_in = data_in;
    assign bus_f.clr = clr;  assign bus_f.wr_en = wr_en;
    assign bus_f.rd_en = rd_en;  assign bus_f.data_in = data_in;

    sync_fifo_param #(.DATA_WIDTH(DW), .DATA_DEPTH(DEPTH), .FWFT(0)) u_std (
        .clk(clk), .rst(rst), .bus(bus_s.slave));
    sync_fifo_param #(.DATA_WIDTH(DW), .DATA_DEPTH(DEPTH), .FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .bus(bus_f.slave));

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of stored words plus the standard-mode output register.
    logic [DW-1:0] q[$];
    logic          m_ovf = 1'b0, m_unf = 1'b0, m_dv = 1'b0;
    logic [DW-1:0] m_dout = '0;
    int            sz;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete(); m_ovf = 0; m_unf = 0; m_dv = 0; m_dout = '0;
        end else if (clr) begin
            q.delete(); m_ovf = 0; m_unf = 0; m_dv = 0;
        end else begin
            sz = q.size();
            if (wr_en && sz == DEPTH) m_ovf = 1;
            if (rd_en && sz == 0)     m_unf = 1;
            m_dv = rd_en && sz > 0;
            if (m_dv) m_dout = q.pop_front();
            if (wr_en && sz < DEPTH) q.push_back(data_in);
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("fill_s", 32'(bus_s.fill_count), 32'(q.size()));
            chk("full_s", 32'(bus_s.full), 32'(q.size() == DEPTH));
            chk("afull_s", 32'(bus_s.almost_full), 32'(q.size() >= DEPTH - 2));
            chk("empty_s", 32'(bus_s.empty), 32'(q.size() == 0));
            chk("aempty_s", 32'(bus_s.almost_empty), 32'(q.size() <= 2));
            chk("ovf_s", 32'(bus_s.overflow), 32'(m_ovf));
            chk("unf_s", 32'(bus_s.underflow), 32'(m_unf));
            chk("dv_s", 32'(bus_s.data_valid), 32'(m_dv));
            chk("dout_s", 32'(bus_s.data_out), 32'(m_dout));
            chk("fill_f", 32'(bus_f.fill_count), 32'(q.size()));
            chk("ovf_f", 32'(bus_f.overflow), 32'(m_ovf));
            chk("unf_f", 32'(bus_f.underflow), 32'(m_unf));
            chk("dv_f", 32'(bus_f.data_valid), 32'(q.size() != 0));
            chk("dout_f", 32'(bus_f.data_out), (q.size() == 0) ? 32'h0 : 32'(q[0]));
        end
    end

    task automatic step(input logic w, input logic [DW-1:0] d, input logic r, input logic c);
        @(negedge clk);
        wr_en = w; data_in = d; rd_en = r; clr = c;
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_fill", 32'(bus_s.fill_count), 32'h0);
        chk("rst_empty", 32'(bus_s.empty), 32'h1);
        chk("rst_aempty", 32'(bus_s.almost_empty), 32'h1);
        chk("rst_full", 32'(bus_s.full), 32'h0);
        chk("rst_dout", 32'(bus_s.data_out), 32'h0);
        chk("rst_dv", 32'(bus_s.data_valid), 32'h0);

        for (int i = 1; i <= 16; i++) step(1'b1, DW'(i), 1'b0, 1'b0);
        idle();
        chk("fill16", 32'(bus_s.fill_count), 32'd16);
        chk("full16", 32'(bus_s.full), 32'h1);
        step(1'b1, 16'h0099, 1'b0, 1'b0);
        idle();
        chk("ovf17", 32'(bus_s.overflow), 32'h1);
        chk("fill17", 32'(bus_s.fill_count), 32'd16);

        for (int i = 1; i <= 16; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            if (i >= 2) chk("rd_order", 32'(bus_s.data_out), 32'(i - 1));
        end
        idle();
        chk("rd_last", 32'(bus_s.data_out), 32'h0010);
        chk("rd_empty", 32'(bus_s.empty), 32'h1);
        step(1'b0, '0, 1'b1, 1'b0);
        idle();
        chk("unf_extra", 32'(bus_s.underflow), 32'h1);

        step(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 13; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0);
        idle();
        chk("afull13", 32'(bus_s.almost_full), 32'h0);
        step(1'b1, DW'($urandom), 1'b0, 1'b0);
        idle();
        chk("afull14", 32'(bus_s.almost_full), 32'h1);
        for (int i = 0; i < 11; i++) step(1'b0, '0, 1'b1, 1'b0);
        idle();
        chk("aempty3", 32'(bus_s.almost_empty), 32'h0);
        step(1'b0, '0, 1'b1, 1'b0);
        idle();
        chk("aempty2", 32'(bus_s.almost_empty), 32'h1);

        step(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, DW'($urandom), 1'b1, 1'b0);
        idle();
        chk("simul8", 32'(bus_s.fill_count), 32'd8);

        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b1, 16'h1234, 1'b1, 1'b0);
        idle();
        chk("rw_empty_fill", 32'(bus_s.fill_count), 32'd1);
        chk("rw_empty_unf", 32'(bus_s.underflow), 32'h1);

        step(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0);
        step(1'b1, 16'h7777, 1'b1, 1'b0);
        idle();
        chk("rw_full_fill", 32'(bus_s.fill_count), 32'd15);
        chk("rw_full_ovf", 32'(bus_s.overflow), 32'h1);

        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b1, 16'hABCD, 1'b0, 1'b0);
        idle();
        chk("fwft_dv", 32'(bus_f.data_valid), 32'h1);
        chk("fwft_dout", 32'(bus_f.data_out), 32'hABCD);
        step(1'b0, '0, 1'b1, 1'b0);
        idle();
        chk("fwft_empty", 32'(bus_f.empty), 32'h1);
        chk("fwft_dout0", 32'(bus_f.data_out), 32'h0);

        step(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 99) < 55, DW'($urandom), $urandom_range(0, 99) < 45,
                 $urandom_range(0, 49) == 0);

        step(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 17; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 11; i++) step(1'b0, '0, 1'b1, 1'b0);
        idle();
        chk("pre_clr_fill", 32'(bus_s.fill_count), 32'd5);
        chk("pre_clr_ovf", 32'(bus_s.overflow), 32'h1);
        step(1'b0, '0, 1'b0, 1'b1);
        idle();
        chk("clr_fill", 32'(bus_s.fill_count), 32'h0);
        chk("clr_empty", 32'(bus_s.empty), 32'h1);
        chk("clr_ovf", 32'(bus_s.overflow), 32'h0);

        for (int i = 0; i < 3; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b1, 16'h5555, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("arst_fill", 32'(bus_s.fill_count), 32'h0);
        chk("arst_empty", 32'(bus_s.empty), 32'h1);
        chk("arst_dout", 32'(bus_s.data_out), 32'h0);
        chk("arst_dv", 32'(bus_s.data_valid), 32'h0);
        chk("arst_fwft_dv", 32'(bus_f.data_valid), 32'h0);
        @(negedge clk);
        wr_en = 1'b0; rd_en = 1'b0; rst = 1'b0;
        repeat (3) idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Parametrised synchronous FIFO for the input and weight buffers. It supersedes the fixed 16x16 counter-style FIFO with the following changes:
- internal read/write pointers instead of externally supplied addresses;
- configurable width and depth;
- programmable almost-full/almost-empty thresholds;
- selectable standard or first-word-fall-through (FWFT) read mode;
- fill-level output, sticky overflow/underflow error flags and a synchronous flush.

It sits between the data loaders and the PE-array feeders.

Parameters:
DATA_WIDTH, 16, bits per word (>=1)
DATA_DEPTH, 16, number of words; power of two, >=4
ADDR_WIDTH, $clog2(DATA_DEPTH), pointer width (derived, not to be overridden)
AFULL_THRESH, DATA_DEPTH-2, almost_full asserted when fill_count >= AFULL_THRESH
AEMPTY_THRESH, 2, almost_empty asserted when fill_count <= AEMPTY_THRESH
FWFT, 0, 0 = standard read (1-cycle latency), 1 = first-word-fall-through

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
clr  in  1  synchronous flush: empties FIFO, clears error flags
wr_en  in  1  write request
data_in  in  DATA_WIDTH  write data
full  out  1  DATA_DEPTH words stored
almost_full  out  1  fill_count >= AFULL_THRESH
rd_en  in  1  read request (FWFT: pop/acknowledge of head word)
data_out  out  DATA_WIDTH  read data
data_valid  out  1  standard mode: data_out updated this cycle; FWFT: equals !empty
empty  out  1  no words stored
almost_empty  out  1  fill_count <= AEMPTY_THRESH
fill_count  out  ADDR_WIDTH+1  words stored, 0..DATA_DEPTH
overflow  out  1  sticky: write attempted while full
underflow  out  1  sticky: read attempted while empty

Behaviour:
- Reset (async assert, sync release):
  - wr_ptr, rd_ptr and fill_count = 0.
  - empty = 1, almost_empty = 1, full = 0, almost_full = 0.
  - data_out = 0, data_valid = 0, overflow = 0, underflow = 0.
  - Memory array is not reset.
- Accept rules are evaluated on flag values before the edge:
  - wr_acc = wr_en & !full; rd_acc = rd_en & !empty.
  - No write-through-when-full: a write while full is dropped even if a read is accepted in the same cycle.
- wr_acc: mem[wr_ptr] <= data_in; wr_ptr increments and wraps DATA_DEPTH-1 -> 0.
- rd_acc: rd_ptr increments and wraps the same way.
- fill_count: +1 on wr_acc only, -1 on rd_acc only, unchanged on both or neither.
- All flags are registered, or decoded combinationally from the registered fill_count. They are valid the cycle after the causing edge.
- Standard mode (FWFT=0):
  - On rd_acc, data_out <= mem[rd_ptr] and data_valid = 1 for one cycle. Otherwise data_valid = 0 and data_out holds.
  - Read latency is 1 cycle.
  - A write to an empty FIFO is readable from the next cycle (empty = 0).
- FWFT mode (FWFT=1):
  - data_out = mem[rd_ptr] whenever !empty; data_valid = !empty.
  - The head word appears one cycle after the write edge into an empty FIFO.
  - rd_acc pops the head; the next word shows the following cycle.
  - While empty, data_out is 0.
- Simultaneous read and write when empty: the read is rejected (underflow set), the write is accepted, and fill_count = 1.
- Simultaneous read and write when full: the read is accepted, the write is dropped (overflow set), and fill_count = DATA_DEPTH-1.
- overflow/underflow stay set until clr or rst.
- clr has priority over wr_en/rd_en in the same cycle. It resets pointers, count and flags exactly as rst does, except data_out holds its value.
- Reset asserted mid-burst: the state clears immediately, without waiting for a clock edge. Data stored before reset is discarded.

Decomposition:
- Package fifo_pkg holds:
  - localparam helpers for ADDR_WIDTH/count width;
  - the read-mode constants FIFO_MODE_STD=0 and FIFO_MODE_FWFT=1.
- Sub-module fifo_mem_2p:
  - DATA_WIDTH x DATA_DEPTH register array;
  - one synchronous write port and one asynchronous read port;
  - no reset.
- Pointer, count, flag and output-register logic stays in sync_fifo_param.

Test Plan:
- Standard mode, depth 16: write 0x0001..0x0010 over 16 cycles.
  - full = 1 and fill_count = 16 after the last edge.
  - 17th write: overflow = 1, contents unchanged.
- Standard mode: read 16 words back.
  - data_out = 0x0001..0x0010 in order, each with data_valid one cycle after rd_en.
  - empty = 1 after the last read.
  - An extra rd_en sets underflow.
- Thresholds: fill to 14 words -> almost_full = 1 at count 14, not at 13. Drain to 2 -> almost_empty = 1.
- Simultaneous read and write at count 8 for 20 cycles: fill_count stays 8; pointers wrap; data ordering is preserved.
- FWFT=1: write 0xABCD into an empty FIFO.
  - Next cycle: data_valid = 1 and data_out = 0xABCD with no rd_en.
  - rd_en pop -> empty = 1 the following cycle.
- clr with 5 words stored and overflow = 1: next cycle fill_count = 0, empty = 1, overflow = 0. Then assert rst async mid-write: all outputs go to reset values before the next edge.
